alu_operand_sequencer: RTL and testbench

Host-side driver for the ALU's serial nibble input. It accepts one command (operand A, operand B, opcode) over a valid/ready handshake and presents it as three 4-bit nibbles on datain, each strobed with a timed read_next pulse. It then waits a fixed latency, captures the ALU's 8-bit result, and returns it with a one-cycle res_valid. It replaces the manual switch/button stimulus, for self-test and for scripted demo sequences.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_operand_sequencer_if.sv | 23 ++
 rtl/alu_strobe_timer.sv | 25 ++
 rtl/alu_operand_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_operand_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, nibble indices and sequencer states shared by the ALU control FSM and its host-side sequencer
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;
    localparam logic [3:0] OP_DIV = 4'h4;
    localparam logic [3:0] OP_CMP = 4'h5;

    localparam logic [1:0] NIB_A  = 2'd0;
    localparam logic [1:0] NIB_B  = 2'd1;
    localparam logic [1:0] NIB_OP = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_WAIT,
        ST_DONE
    } seq_state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP};
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// alu_operand_sequencer_if: host command/result handshake between a master and the sequencer
interface alu_operand_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] cmd_op;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op,
        input  cmd_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op,
        output cmd_ready, res_valid, res_data, res_err
    );

endinterface

// File: rtl/alu_strobe_timer.sv
// alu_strobe_timer: loadable down-counter; done while the count sits at zero
module alu_strobe_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: takes one A/B/op command and feeds it to the ALU as three strobed nibbles,
// then returns the ALU result after a fixed latency (or an immediate error for an illegal opcode).
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int PULSE_CYC  = 4,
    parameter int GAP_CYC    = 4,
    parameter int RESULT_LAT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    alu_operand_sequencer_if.slave  host,
    output logic [3:0]              datain,
    output logic                    read_next,
    input  logic [7:0]              alu_y,
    output logic                    busy
);

    localparam int MAX_SP = SETUP_CYC > PULSE_CYC ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_GR = GAP_CYC > RESULT_LAT ? GAP_CYC : RESULT_LAT;
    localparam int MAX_P  = MAX_SP > MAX_GR ? MAX_SP : MAX_GR;
    localparam int CW     = $clog2(MAX_P + 1);

    seq_state_e state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] a_q, a_d, b_q, b_d, op_q, op_d;
    logic       err_q, err_d;
    logic [3:0] datain_q, datain_d;
    logic       read_next_q, read_next_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       busy_q, busy_d;
    logic       res_valid_q, res_valid_d;
    logic [7:0] res_data_q, res_data_d;
    logic       res_err_q, res_err_d;
    logic          tmr_load, tmr_done;
    logic [CW-1:0] tmr_val;

    alu_strobe_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        err_d       = err_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        case (state_q)
            ST_IDLE: if (host.cmd_valid && cmd_ready_q) begin
                a_d     = host.cmd_a;
                b_d     = host.cmd_b;
                op_d    = host.cmd_op;
                idx_d   = NIB_A;
                err_d   = !is_legal_op(host.cmd_op);
                state_d = err_d ? ST_DONE : ST_SETUP;
            end
            ST_SETUP: if (tmr_done) state_d = ST_PULSE;
            ST_PULSE: if (tmr_done) state_d = ST_GAP;
            ST_GAP: if (tmr_done) begin
                state_d = (idx_q == NIB_OP) ? ST_WAIT : ST_SETUP;
                idx_d   = (idx_q == NIB_OP) ? idx_q : idx_q + 2'd1;
            end
            ST_WAIT: if (tmr_done) state_d = ST_DONE;
            ST_DONE: begin
                state_d     = ST_IDLE;
                res_valid_d = 1'b1;
                res_err_d   = err_q;
                res_data_d  = err_q ? 8'h00 : alu_y;
            end
            default: state_d = ST_IDLE;
        endcase
        // Every state change reloads the timer with the new state's length minus one.
        tmr_load    = (state_d != state_q);
        tmr_val     = state_d == ST_SETUP ? CW'(SETUP_CYC - 1) :
                      state_d == ST_PULSE ? CW'(PULSE_CYC - 1) :
                      state_d == ST_GAP   ? CW'(GAP_CYC - 1)   :
                      state_d == ST_WAIT  ? CW'(RESULT_LAT - 1) : '0;
        datain_d    = (state_d inside {ST_SETUP, ST_PULSE, ST_GAP}) ?
                      (idx_d == NIB_A ? a_d : idx_d == NIB_B ? b_d : op_d) : 4'h0;
        read_next_d = (state_d == ST_PULSE);
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= NIB_A;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            err_q       <= 1'b0;
            datain_q    <= '0;
            read_next_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            err_q       <= err_d;
            datain_q    <= datain_d;
            read_next_q <= read_next_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
        end
    end

    assign datain         = datain_q;
    assign read_next      = read_next_q;
    assign busy           = busy_q;
    assign host.cmd_ready = cmd_ready_q;
    assign host.res_valid = res_valid_q;
    assign host.res_data  = res_data_q;
    assign host.res_err   = res_err_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed vectors against a default-timed and a fast-timed sequencer,
// with a small ALU stand-in that computes alu_y from the nibbles it sees strobed.
module tb_alu_operand_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_operand_sequencer_if h1 ();
    alu_operand_sequencer_if h2 ();

    logic [3:0] din1, din2;
    logic       rn1, rn2, busy1, busy2;
    logic [7:0] y1 = 8'h00, y2 = 8'h00;

    alu_operand_sequencer u1 (
        .clk(clk), .reset(reset), .host(h1),
        .datain(din1), .read_next(rn1), .alu_y(y1), .busy(busy1)
    );

    alu_operand_sequencer #(
        .SETUP_CYC(1), .PULSE_CYC(1), .GAP_CYC(1), .RESULT_LAT(1)
    ) u2 (
        .clk(clk), .reset(reset), .host(h2),
        .datain(din2), .read_next(rn2), .alu_y(y2), .busy(busy2)
    );

    logic       cv = 1'b0;
    logic [3:0] ca = 4'h0, cb = 4'h0, cop = 4'h0;
    int         sel = 0;

    assign h1.cmd_valid = cv && sel == 0;
    assign h1.cmd_a     = ca;
    assign h1.cmd_b     = cb;
    assign h1.cmd_op    = cop;
    assign h2.cmd_valid = cv && sel == 1;
    assign h2.cmd_a     = ca;
    assign h2.cmd_b     = cb;
    assign h2.cmd_op    = cop;

    logic       rn, rv, rdy, er, bsy;
    logic [3:0] din;
    logic [7:0] rd;
    assign rn  = sel == 0 ? rn1 : rn2;
    assign din = sel == 0 ? din1 : din2;
    assign bsy = sel == 0 ? busy1 : busy2;
    assign rv  = sel == 0 ? h1.res_valid : h2.res_valid;
    assign rdy = sel == 0 ? h1.cmd_ready : h2.cmd_ready;
    assign er  = sel == 0 ? h1.res_err : h2.res_err;
    assign rd  = sel == 0 ? h1.res_data : h2.res_data;

    int n_run = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] alu_model(input logic [3:0] a, b, op);
        case (op)
            OP_ADD:  return 8'(a) + 8'(b);
            OP_SUB:  return 8'(a) - 8'(b);
            OP_MUL:  return 8'(a) * 8'(b);
            OP_DIV:  return b == 4'h0 ? 8'hFF : 8'(a / b);
            OP_CMP:  return a > b ? 8'h01 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic set_y(input logic [7:0] v);
        if (sel == 0) y1 = v;
        else          y2 = v;
    endtask

    // Starts at a negedge; compares the full datain/read_next trace and the result timing.
    task automatic run(input string tag, input logic [3:0] a, b, op, input logic [7:0] exp,
                       input int s, p, g, r, input bit chain, input bit poke,
                       input logic [3:0] na, nb, nop);
        int l, seg, errs, nres, k;
        logic [3:0] nib[3];
        logic [3:0] want[3];
        logic exp_rn, rn_prev;
        l = 3 * (s + p + g) + r + 1;
        seg = s + p + g;
        errs = 0;
        nres = 0;
        k = 0;
        rn_prev = 1'b0;
        want[0] = a;
        want[1] = b;
        want[2] = op;
        set_y(8'h00);
        check({tag, ".ready"}, rdy, 1);
        cv = 1'b1; ca = a; cb = b; cop = op;
        @(posedge clk);
        for (int j = 0; j <= l; j++) begin
            @(negedge clk);
            if (j == 0 && !chain) cv = 1'b0;
            if (j == 0) check({tag, ".busy"}, bsy, 1);
            if (poke && j == 5) begin cv = 1'b1; ca = ~a; cb = ~b; cop = OP_ADD; end
            if (poke && j == 21) cv = 1'b0;
            if (j < 3 * seg) begin
                exp_rn = (j % seg) >= s && (j % seg) < s + p;
                if (din !== want[j / seg]) errs++;
            end else exp_rn = 1'b0;
            if (rn !== exp_rn) errs++;
            if (rn && !rn_prev && k < 3) begin
                nib[k] = din;
                k++;
                if (k == 3) set_y(alu_model(nib[0], nib[1], nib[2]));
            end
            rn_prev = rn;
            if (rv) begin
                nres++;
                if (j != l) errs++;
            end
            if (j == l) begin
                check({tag, ".data"}, rd, exp);
                check({tag, ".err"}, er, 0);
            end
        end
        check({tag, ".trace"}, errs, 0);
        check({tag, ".pulses"}, k, 3);
        check({tag, ".nres"}, nres, 1);
        if (chain) begin
            cv = 1'b1; ca = na; cb = nb; cop = nop;
        end else begin
            @(negedge clk);
            check({tag, ".rv_width"}, rv, 0);
        end
    endtask

    initial begin
        int cnt;
        #12;
        check("rst.ready", rdy, 1);
        check("rst.rv", rv, 0);
        check("rst.data", rd, 0);
        check("rst.err", er, 0);
        check("rst.busy", bsy, 0);
        check("rst.rn", rn, 0);
        check("rst.din", din, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run("add", 4'h5, 4'h3, OP_ADD, 8'h08, 2, 4, 4, 3, 0, 0, 0, 0, 0);
        run("mul", 4'hF, 4'hF, OP_MUL, 8'hE1, 2, 4, 4, 3, 0, 1, 0, 0, 0);

        check("ill.ready", rdy, 1);
        cv = 1'b1; ca = 4'h1; cb = 4'h2; cop = 4'h9;
        @(posedge clk);
        @(negedge clk);
        cv = 1'b0;
        check("ill.rv0", rv, 0);
        check("ill.ready0", rdy, 0);
        check("ill.rn0", rn, 0);
        @(negedge clk);
        check("ill.rv1", rv, 1);
        check("ill.err1", er, 1);
        check("ill.data1", rd, 0);
        check("ill.ready1", rdy, 1);
        check("ill.rn1", rn, 0);
        check("ill.din1", din, 0);
        @(negedge clk);
        check("ill.rv2", rv, 0);

        cv = 1'b1; ca = 4'h6; cb = 4'h7; cop = OP_ADD;
        @(posedge clk);
        @(negedge clk);
        cv = 1'b0;
        repeat (12) @(negedge clk);
        check("abort.rn_pre", rn, 1);
        check("abort.din_pre", din, 4'h7);
        #2 reset = 1'b0;
        #1;
        check("abort.rn", rn, 0);
        check("abort.din", din, 0);
        check("abort.busy", bsy, 0);
        cnt = 0;
        repeat (3) begin @(negedge clk); if (rv) cnt++; end
        reset = 1'b1;
        repeat (37) begin @(negedge clk); if (rv) cnt++; end
        check("abort.nres", cnt, 0);
        run("sub", 4'h9, 4'h2, OP_SUB, 8'h07, 2, 4, 4, 3, 0, 0, 0, 0, 0);

        run("b2b1", 4'h2, 4'h3, OP_ADD, 8'h05, 2, 4, 4, 3, 1, 0, 4'h8, 4'h2, OP_DIV);
        run("b2b2", 4'h8, 4'h2, OP_DIV, 8'h04, 2, 4, 4, 3, 0, 0, 0, 0, 0);

        sel = 1;
        run("fast", 4'h7, 4'h6, OP_CMP, 8'h01, 1, 1, 1, 1, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
